// File: rtl/uart_relay_sequencer.sv
// uart_relay_sequencer
//   Command sequencer between a uart_rx byte stream and the board actuators.
//   Parses opcode/argument commands, drives relay levels and one timed relay
//   pulse, sets the RGB colour, and answers each command with a single
//   response byte through a start/busy handshake to a uart_tx.
//
//   Optional feature macro: STATUS_QUERY_EN
//     defined   -> 0x53 'S' is a one-byte status query answered with
//                  {pulse_active, rgb[2:0], relay zero-extended to 4 bits}
//     undefined -> 0x53 is an unknown opcode (NAK + err)
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   rx_byte   received byte, qualified by rx_valid
//   rx_valid  one-cycle strobe from uart_rx
//   tx_byte   response byte, stable while tx_start is high
//   tx_start  one-cycle transmit request
//   tx_busy   uart_tx busy (rises the cycle after tx_start)
//   relay     relay drive, active-high logical
//   rgb       LED colour {B,G,R}
//   err       one-cycle protocol error strobe

module uart_relay_sequencer #(
    parameter int unsigned NUM_RELAYS        = 2,
    parameter int unsigned TICK_CYCLES       = 12000,
    parameter int unsigned ARG_TIMEOUT_TICKS = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [7:0]            tx_byte,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic [NUM_RELAYS-1:0] relay,
    output logic [2:0]            rgb,
    output logic                  err
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned TO_W   = $clog2(ARG_TIMEOUT_TICKS + 1);

    localparam logic [7:0] OP_ON     = 8'h4E;
    localparam logic [7:0] OP_OFF    = 8'h46;
    localparam logic [7:0] OP_PULSE  = 8'h50;
    localparam logic [7:0] OP_COLOR  = 8'h43;
    localparam logic [7:0] OP_STATUS = 8'h53;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [1:0] {
        IDLE,
        ARG,
        EXEC,
        RESP
    } state_t;

    state_t                  state, state_n;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic [TO_W-1:0]         to_cnt, to_cnt_n;
    logic [7:0]              opcode, opcode_n;
    logic [7:0]              arg, arg_n;
    logic                    pulse_active, pulse_active_n;
    logic [1:0]              pulse_idx, pulse_idx_n;
    logic [5:0]              pulse_cnt, pulse_cnt_n;
    logic [NUM_RELAYS-1:0]   relay_n;
    logic [2:0]              rgb_n;
    logic [7:0]              tx_byte_n;
    logic                    tx_start_n;
    logic                    err_n;
    logic                    exec_ok;
    logic                    status_rsp;
    logic [7:0]              p_sel;
    logic                    nf_sel_ok;
    logic                    p_sel_ok;
    logic [7:0]              status_byte;

    // Relay index decode for N/F (whole byte) and P (arg[7:6])
    assign p_sel       = {6'd0, arg[7:6]};
    assign nf_sel_ok   = (arg < 8'(NUM_RELAYS));
    assign p_sel_ok    = (p_sel < 8'(NUM_RELAYS));
    assign status_byte = {pulse_active, rgb, 4'(relay)};

    // Free-running timebase; tick marks the wrap cycle
    assign tick = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            to_cnt       <= '0;
            opcode       <= 8'h00;
            arg          <= 8'h00;
            pulse_active <= 1'b0;
            pulse_idx    <= 2'd0;
            pulse_cnt    <= 6'd0;
            relay        <= '0;
            rgb          <= 3'b001;
            tx_byte      <= 8'h00;
            tx_start     <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            to_cnt       <= to_cnt_n;
            opcode       <= opcode_n;
            arg          <= arg_n;
            pulse_active <= pulse_active_n;
            pulse_idx    <= pulse_idx_n;
            pulse_cnt    <= pulse_cnt_n;
            relay        <= relay_n;
            rgb          <= rgb_n;
            tx_byte      <= tx_byte_n;
            tx_start     <= tx_start_n;
            err          <= err_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n        = state;
        to_cnt_n       = to_cnt;
        opcode_n       = opcode;
        arg_n          = arg;
        pulse_active_n = pulse_active;
        pulse_idx_n    = pulse_idx;
        pulse_cnt_n    = pulse_cnt;
        relay_n        = relay;
        rgb_n          = rgb;
        tx_byte_n      = tx_byte;
        tx_start_n     = 1'b0;
        err_n          = 1'b0;
        exec_ok        = 1'b0;
        status_rsp     = 1'b0;

        // Pulse expiry is evaluated first so a same-cycle EXEC N/F overrides it
        if (pulse_active && tick) begin
            pulse_cnt_n = pulse_cnt - 6'd1;
            if (pulse_cnt == 6'd1) begin
                pulse_active_n = 1'b0;
                for (int i = 0; i < NUM_RELAYS; i++) begin
                    if (pulse_idx == 2'(i)) begin
                        relay_n[i] = 1'b0;
                    end
                end
            end
        end

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    opcode_n = rx_byte;
                    if (rx_byte == OP_ON || rx_byte == OP_OFF ||
                        rx_byte == OP_PULSE || rx_byte == OP_COLOR) begin
                        state_n  = ARG;
                        to_cnt_n = '0;
`ifdef STATUS_QUERY_EN
                    end else if (rx_byte == OP_STATUS) begin
                        state_n = EXEC;
`endif
                    end else begin
                        state_n    = RESP;
                        tx_byte_n  = RSP_NAK;
                        tx_start_n = !tx_busy;
                        err_n      = 1'b1;
                    end
                end
            end

            ARG: begin
                if (rx_valid) begin
                    arg_n   = rx_byte;
                    state_n = EXEC;
                end else if (tick) begin
                    if (to_cnt == TO_W'(ARG_TIMEOUT_TICKS - 1)) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + TO_W'(1);
                    end
                end
            end

            EXEC: begin
                state_n = RESP;
                // Pre-arm the request so an idle transmitter starts next cycle
                tx_start_n = !tx_busy;
                case (opcode)
                    OP_ON, OP_OFF: begin
                        if (nf_sel_ok) begin
                            exec_ok = 1'b1;
                            for (int i = 0; i < NUM_RELAYS; i++) begin
                                if (8'(i) == arg) begin
                                    relay_n[i] = (opcode == OP_ON);
                                end
                            end
                            if (pulse_active && ({6'd0, pulse_idx} == arg)) begin
                                pulse_active_n = 1'b0;
                            end
                        end
                    end
                    OP_PULSE: begin
                        if (p_sel_ok && (arg[5:0] != 6'd0) && !pulse_active) begin
                            exec_ok = 1'b1;
                            for (int i = 0; i < NUM_RELAYS; i++) begin
                                if (8'(i) == p_sel) begin
                                    relay_n[i] = 1'b1;
                                end
                            end
                            pulse_active_n = 1'b1;
                            pulse_idx_n    = arg[7:6];
                            pulse_cnt_n    = arg[5:0];
                        end
                    end
                    OP_COLOR: begin
                        exec_ok = 1'b1;
                        rgb_n   = arg[2:0];
                    end
`ifdef STATUS_QUERY_EN
                    OP_STATUS: begin
                        exec_ok    = 1'b1;
                        status_rsp = 1'b1;
                    end
`endif
                    default: begin
                        exec_ok = 1'b0;
                    end
                endcase
                if (status_rsp) begin
                    tx_byte_n = status_byte;
                end else begin
                    tx_byte_n = exec_ok ? RSP_ACK : RSP_NAK;
                end
                err_n = !exec_ok || rx_valid;
            end

            RESP: begin
                if (rx_valid) begin
                    err_n = 1'b1;
                end
                if (tx_start) begin
                    state_n = IDLE;
                end else if (!tx_busy) begin
                    tx_start_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
